matrix_burst_sender: RTL

Downstream of the size-traverse sequencer; consumes its `matrix_burst_en` and `send_trig` pulses. On `matrix_burst_en` it reads one row-major matrix of up to 5×5 elements from matrix storage into an internal buffer and raises `buf_full`. On `send_trig` it streams the matrix as ASCII text over a byte handshake to the UART transmitter, then pulses `send_done`.

---
 rtl/matrix_pkg.sv | 31 +++
 rtl/matrix_elem_buffer.sv | 26 ++
 rtl/matrix_burst_sender.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and ASCII helper for matrix_burst_sender.
package matrix_pkg;

  localparam int MAX_DIM = 5;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_X  = 8'h78;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    LOAD_WAIT,
    FULL,
    HDR,
    ELEM,
    SEP,
    CR,
    LF,
    DONE
  } state_e;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASC_0 + {4'h0, n}
                       : ASC_A + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/matrix_elem_buffer.sv
// Element store: one synchronous write port, one asynchronous read port.
module matrix_elem_buffer #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 25,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads one past the last row are harmless and return zero.
  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/matrix_burst_sender.sv
// Loads an RxC matrix from storage and streams it as ASCII hex text.
// Define MATRIX_TX_HEADER_EN to prefix the text with an "RxC" line.
module matrix_burst_sender #(
  parameter int DATA_W  = 4,
  parameter int MAX_DIM = 5,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              matrix_burst_en,
  input  logic [2:0]        sel_row,
  input  logic [2:0]        sel_col,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              buf_full,
  output logic              buf_err,
  input  logic              send_trig,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              send_done,
  output logic              busy
);
  import matrix_pkg::*;

  state_e            state_q;
  logic [2:0]        r_dim_q, c_dim_q;
  logic [2:0]        row_q, col_q, hdr_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] wa_q;
  logic              mem_rd_en_q, buf_full_q, buf_err_q;
  logic              tx_valid_q, send_done_q, busy_q;
  logic [ADDR_W-1:0] mem_rd_addr_q;
  logic [7:0]        tx_data_q;
  logic [ADDR_W-1:0] raddr_d;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        elem_ch;
  logic              dims_ok;
  logic              row_last, col_last;

  function automatic logic [ADDR_W-1:0] lin(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return ADDR_W'(r) * ADDR_W'(c_dim_q) + ADDR_W'(c);
  endfunction

  assign dims_ok  = (sel_row != 3'd0) && (int'(sel_row) <= MAX_DIM)
                 && (sel_col != 3'd0) && (int'(sel_col) <= MAX_DIM);
  assign row_last = (row_q == r_dim_q - 3'd1);
  assign col_last = (col_q == c_dim_q - 3'd1);

  // Read address points at the element the next transfer will present.
  always_comb begin
    raddr_d = '0;
    case (state_q)
      SEP:     raddr_d = lin(row_q, col_q + 3'd1);
      LF:      raddr_d = lin(row_q + 3'd1, 3'd0);
      default: raddr_d = '0;
    endcase
  end

  assign elem_ch = hex_ascii(4'(rdata));

  matrix_elem_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DIM * MAX_DIM),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (rd_pend_q),
    .waddr_i (wa_q),
    .wdata_i (mem_rd_data),
    .raddr_i (raddr_d),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      r_dim_q       <= 3'd0;
      c_dim_q       <= 3'd0;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      hdr_q         <= 3'd0;
      rd_pend_q     <= 1'b0;
      wa_q          <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      buf_full_q    <= 1'b0;
      buf_err_q     <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      send_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      buf_err_q   <= 1'b0;
      send_done_q <= 1'b0;
      rd_pend_q   <= mem_rd_en_q;
      wa_q        <= mem_rd_addr_q;
      case (state_q)
        IDLE: begin
          if (matrix_burst_en) begin
            if (dims_ok) begin
              r_dim_q       <= sel_row;
              c_dim_q       <= sel_col;
              row_q         <= 3'd0;
              col_q         <= 3'd0;
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= '0;
              busy_q        <= 1'b1;
              state_q       <= LOAD;
            end else begin
              buf_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (row_last && col_last) begin
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            state_q       <= LOAD_WAIT;
          end else if (col_last) begin
            row_q         <= row_q + 3'd1;
            col_q         <= 3'd0;
            mem_rd_addr_q <= lin(row_q + 3'd1, 3'd0);
          end else begin
            col_q         <= col_q + 3'd1;
            mem_rd_addr_q <= lin(row_q, col_q + 3'd1);
          end
        end
        LOAD_WAIT: begin
          buf_full_q <= 1'b1;
          state_q    <= FULL;
        end
        FULL: begin
          if (send_trig) begin
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            hdr_q      <= 3'd0;
            tx_valid_q <= 1'b1;
`ifdef MATRIX_TX_HEADER_EN
            tx_data_q  <= ASC_0 + {5'd0, r_dim_q};
            state_q    <= HDR;
`else
            tx_data_q  <= elem_ch;
            state_q    <= ELEM;
`endif
          end
        end
        HDR: begin
          if (tx_ready) begin
            hdr_q <= hdr_q + 3'd1;
            case (hdr_q)
              3'd0:    tx_data_q <= ASC_X;
              3'd1:    tx_data_q <= ASC_0 + {5'd0, c_dim_q};
              3'd2:    tx_data_q <= ASC_CR;
              3'd3:    tx_data_q <= ASC_LF;
              default: begin
                tx_data_q <= elem_ch;
                state_q   <= ELEM;
              end
            endcase
          end
        end
        ELEM: begin
          if (tx_ready) begin
            tx_data_q <= col_last ? ASC_CR : ASC_SP;
            state_q   <= col_last ? CR : SEP;
          end
        end
        SEP: begin
          if (tx_ready) begin
            col_q     <= col_q + 3'd1;
            tx_data_q <= elem_ch;
            state_q   <= ELEM;
          end
        end
        CR: begin
          if (tx_ready) begin
            tx_data_q <= ASC_LF;
            state_q   <= LF;
          end
        end
        LF: begin
          if (tx_ready) begin
            if (row_last) begin
              tx_valid_q  <= 1'b0;
              tx_data_q   <= 8'h00;
              send_done_q <= 1'b1;
              buf_full_q  <= 1'b0;
              state_q     <= DONE;
            end else begin
              row_q     <= row_q + 3'd1;
              col_q     <= 3'd0;
              tx_data_q <= elem_ch;
              state_q   <= ELEM;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign buf_full    = buf_full_q;
  assign buf_err     = buf_err_q;
  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign send_done   = send_done_q;
  assign busy        = busy_q;

endmodule
